// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the byte-wide RAM arbiter: FSM states, access size codes, RAM timing.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [1:0]  MEM_BYTE    = 2'b00;
   localparam logic [1:0]  MEM_HALF    = 2'b01;
   localparam logic [1:0]  MEM_WORD    = 2'b10;
   localparam int          RAM_LATENCY = 1;
   localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

   // Size code 11 is treated as a full word.
   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         MEM_BYTE: return 3'd1;
         MEM_HALF: return 3'd2;
         default:  return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester (IF/MEM) and RAM-side signals of the arbiter; slave = arbiter, master = environment.
interface mem_arbiter_if #(parameter int ADDR_WIDTH = 32);

   logic                  if_req_i;
   logic [ADDR_WIDTH-1:0] if_addr_i;
   logic                  if_rdy_o;
   logic [31:0]           if_data_o;

   logic                  mem_req_i;
   logic                  mem_we_i;
   logic [1:0]            mem_size_i;
   logic [ADDR_WIDTH-1:0] mem_addr_i;
   logic [31:0]           mem_wdata_i;
   logic                  mem_rdy_o;
   logic [31:0]           mem_rdata_o;

   logic [ADDR_WIDTH-1:0] ram_addr_o;
   logic                  ram_wr_o;
   logic [7:0]            ram_dout_o;
   logic [7:0]            ram_din_i;

   logic                  busy_o;

   modport slave (
      input  if_req_i, if_addr_i,
      input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
      input  ram_din_i,
      output if_rdy_o, if_data_o, mem_rdy_o, mem_rdata_o,
      output ram_addr_o, ram_wr_o, ram_dout_o, busy_o
   );

   modport master (
      output if_req_i, if_addr_i,
      output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
      output ram_din_i,
      input  if_rdy_o, if_data_o, mem_rdy_o, mem_rdata_o,
      input  ram_addr_o, ram_wr_o, ram_dout_o, busy_o
   );

endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (MEM over IF) arbiter serialising 1/2/4-byte accesses onto a byte RAM.
// Read rdy N+2 cycles after grant, write rdy N+1; requesters hold until their one-cycle rdy.
import mem_arbiter_pkg::*;

module mem_arbiter #(
   parameter int ADDR_WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] base, base_nxt;
   logic [ADDR_WIDTH-1:0] ram_addr, ram_addr_nxt;
   logic                  ram_wr, ram_wr_nxt;
   logic [7:0]            ram_dout, ram_dout_nxt;
   logic                  if_rdy, if_rdy_nxt;
   logic                  mem_rdy, mem_rdy_nxt;
   logic [31:0]           if_data, if_data_nxt;
   logic [31:0]           mem_rdata, mem_rdata_nxt;
   logic [31:0]           wdata, wdata_nxt;
   logic [31:0]           shift, shift_nxt;
   logic [31:0]           assembled;
   logic [2:0]            nbytes, nbytes_nxt;
   logic [2:0]            cnt, cnt_nxt;
   logic                  sel_mem, sel_mem_nxt;

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         base      <= '0;
         ram_addr  <= '0;
         ram_wr    <= 1'b0;
         ram_dout  <= 8'h00;
         if_rdy    <= 1'b0;
         mem_rdy   <= 1'b0;
         if_data   <= ZERO_WORD;
         mem_rdata <= ZERO_WORD;
         wdata     <= ZERO_WORD;
         shift     <= ZERO_WORD;
         nbytes    <= 3'd0;
         cnt       <= 3'd0;
         sel_mem   <= 1'b0;
      end else begin
         base      <= base_nxt;
         ram_addr  <= ram_addr_nxt;
         ram_wr    <= ram_wr_nxt;
         ram_dout  <= ram_dout_nxt;
         if_rdy    <= if_rdy_nxt;
         mem_rdy   <= mem_rdy_nxt;
         if_data   <= if_data_nxt;
         mem_rdata <= mem_rdata_nxt;
         wdata     <= wdata_nxt;
         shift     <= shift_nxt;
         nbytes    <= nbytes_nxt;
         cnt       <= cnt_nxt;
         sel_mem   <= sel_mem_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      base_nxt      = base;
      ram_addr_nxt  = ram_addr;
      ram_wr_nxt    = ram_wr;
      ram_dout_nxt  = ram_dout;
      if_rdy_nxt    = if_rdy;
      mem_rdy_nxt   = mem_rdy;
      if_data_nxt   = if_data;
      mem_rdata_nxt = mem_rdata;
      wdata_nxt     = wdata;
      shift_nxt     = shift;
      nbytes_nxt    = nbytes;
      cnt_nxt       = cnt;
      sel_mem_nxt   = sel_mem;

      // In READ, cnt-1 is the index of the byte currently on ram_din_i.
      assembled = shift;
      assembled[{cnt[1:0] - 2'd1, 3'b000} +: 8] = bus.ram_din_i;

      case (state)
         IDLE: begin
            if (bus.mem_req_i || bus.if_req_i) begin
               sel_mem_nxt  = bus.mem_req_i;
               base_nxt     = bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
               ram_addr_nxt = bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
               nbytes_nxt   = bus.mem_req_i ? size_bytes(bus.mem_size_i) : 3'd4;
               wdata_nxt    = bus.mem_wdata_i;
               cnt_nxt      = 3'd0;
               shift_nxt    = ZERO_WORD;
               if (bus.mem_req_i && bus.mem_we_i) begin
                  ram_wr_nxt   = 1'b1;
                  ram_dout_nxt = bus.mem_wdata_i[7:0];
                  state_nxt    = WRITE;
               end else begin
                  state_nxt    = READ;
               end
            end
         end
         READ: begin
            cnt_nxt = cnt + 3'd1;
            if (cnt + 3'd1 < nbytes)
               ram_addr_nxt = base + ADDR_WIDTH'(cnt + 3'd1);
            if (cnt >= 3'(RAM_LATENCY))
               shift_nxt = assembled;
            if (cnt == nbytes) begin
               if_rdy_nxt  = !sel_mem;
               mem_rdy_nxt = sel_mem;
               if (sel_mem) mem_rdata_nxt = assembled;
               else         if_data_nxt   = assembled;
               state_nxt   = DONE;
            end
         end
         WRITE: begin
            if (cnt + 3'd1 == nbytes) begin
               ram_wr_nxt  = 1'b0;
               mem_rdy_nxt = 1'b1;
               state_nxt   = DONE;
            end else begin
               cnt_nxt      = cnt + 3'd1;
               ram_addr_nxt = base + ADDR_WIDTH'(cnt + 3'd1);
               ram_dout_nxt = wdata[{cnt[1:0] + 2'd1, 3'b000} +: 8];
            end
         end
         DONE: begin
            if_rdy_nxt   = 1'b0;
            mem_rdy_nxt  = 1'b0;
            ram_addr_nxt = '0;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.ram_addr_o  = ram_addr;
   assign bus.ram_wr_o    = ram_wr;
   assign bus.ram_dout_o  = ram_dout;
   assign bus.if_rdy_o    = if_rdy;
   assign bus.if_data_o   = if_data;
   assign bus.mem_rdy_o   = mem_rdy;
   assign bus.mem_rdata_o = mem_rdata;
   assign bus.busy_o      = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the MEM stage's load/store path.
- Sequences each 1/2/4-byte access as consecutive byte cycles and assembles little-endian read data.
- Returns a one-cycle ready pulse to the winning requester.
- Sits between the IF/MEM stages and the RAM. IF and MEM hold their requests until ready; the pipeline controller stalls on outstanding requests.

Parameters:
- ADDR_WIDTH, 32, width of all address buses.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req_i  in  1  IF fetch request; held until if_rdy_o.
- if_addr_i  in  ADDR_WIDTH  fetch byte address.
- if_rdy_o  out  1  one-cycle pulse: if_data_o valid.
- if_data_o  out  32  fetched instruction, little-endian.
- mem_req_i  in  1  MEM access request; held until mem_rdy_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_addr_i  in  ADDR_WIDTH  access byte address.
- mem_wdata_i  in  32  store data; low bytes used first.
- mem_rdy_o  out  1  one-cycle pulse: load data valid or store complete.
- mem_rdata_o  out  32  load data, zero-extended (MEM stage does sign extension).
- ram_addr_o  out  ADDR_WIDTH  RAM byte address (registered).
- ram_wr_o  out  1  RAM write strobe (registered).
- ram_dout_o  out  8  RAM write byte (registered).
- ram_din_i  in  8  RAM read byte; valid the cycle after its address was presented (1-cycle latency).
- busy_o  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst==0 at a rising edge):
  - state<=IDLE; ram_addr_o<=0, ram_wr_o<=0, ram_dout_o<=0.
  - if_rdy_o<=0, mem_rdy_o<=0; if_data_o<=0, mem_rdata_o<=0.
  - Byte counter and shift register cleared.
  - Reset mid-transaction aborts it at that edge. Bytes already written stay in RAM; no rdy is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE grant:
  - At an edge with mem_req_i=1, grant MEM. Otherwise, if if_req_i=1, grant IF.
  - MEM has fixed priority; when both request, IF waits.
  - On grant, latch addr, we, and N bytes (IF: N=4; MEM: 1/2/4 from size).
  - Also latch wdata, and load ram_addr_o<=addr.
  - MEM store: ram_wr_o<=1, ram_dout_o<=wdata[7:0], state<=WRITE. Otherwise state<=READ.
  - Requester inputs changing after grant are ignored.
- Cycle numbering: c1 is the cycle after the grant edge; edge Ek ends ck.
- READ:
  - ram_addr_o = A+k during c(k+1), k=0..N-1.
  - Byte M[A+k] is present on ram_din_i in c(k+2), captured at E(k+2) into result byte k.
  - After address A+N-1, ram_addr_o holds its value.
  - At E(N+1), the final byte is captured, the selected rdy<=1, data output<=result, state<=DONE.
  - Rdy is therefore high in c(N+2): word = 6 cycles after grant, byte = 3.
- WRITE:
  - During ck, k=1..N: ram_wr_o=1, ram_addr_o=A+k-1, ram_dout_o=wdata byte k-1.
  - At EN: ram_wr_o<=0, mem_rdy_o<=1, state<=DONE. Rdy is high in c(N+1).
- DONE: lasts exactly one cycle with rdy high. It then clears rdy, sets ram_addr_o<=0, and returns to IDLE.
  - Requests are never sampled in DONE, so a held request is not re-granted.
  - A new request is granted no earlier than the edge ending the first IDLE cycle.
- Rdy and data:
  - At most one of if_rdy_o / mem_rdy_o is high in any cycle.
  - if_data_o / mem_rdata_o hold their last value until the next completion.
  - Unused upper bytes of mem_rdata_o are 0.
- Address arithmetic is modulo 2^ADDR_WIDTH; A=FFFFFFFF with N=2 accesses FFFFFFFF then 00000000.

Decomposition:
- Shared defines file: state encodings.
- Shared defines file: size codes MemByte/MemHalf/MemWord.
- Shared defines file: RamLatency=1.
- Shared defines file: reuse ZeroWord and the existing enable macros.
- No sub-module; a single FSM plus byte counter and shift register.

Test Plan:
- IF only, addr 0x10, RAM[0x10..0x13]=13,00,05,93 → if_rdy_o high in c6, if_data_o=0x93050013; ram_wr_o never high.
- MEM store word 0xDEADBEEF at 0x20 → ram_wr_o high c1..c4 with (0x20,EF),(0x21,BE),(0x22,AD),(0x23,DE); mem_rdy_o high in c5.
- Same-edge IF (0x0) and MEM load byte (0x20) → MEM granted first, mem_rdy_o in c3, mem_rdata_o=0x000000EF.
  - IF granted at the edge after the following IDLE cycle; if_rdy_o never coincides with mem_rdy_o.
- Requests held high through DONE → each request is serviced exactly once; busy_o is low for exactly one cycle between transactions.
- Half load at 0xFFFFFFFF with RAM[FFFFFFFF]=34, RAM[0]=12 → addresses FFFFFFFF, 00000000; mem_rdata_o=0x00001234.
- rst=0 for one edge during c2 of a word store → ram_wr_o=0 from the next cycle, state IDLE, no mem_rdy_o.
  - The request still held after reset is re-granted from scratch.
